// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Register write-pending scoreboard for an in-order issue stage.
//               Holds one countdown per architectural register, flags RAW
//               (source) and WAW (destination) hazards combinationally,
//               reports forwardable operands and counts stalled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 3,
  parameter int LAT_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_dest,
  input  logic                      issue_wb_en,
  input  logic [LAT_W-1:0]          issue_lat,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic                      fwd_en,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC-1:0]        fwd_hit,
  output logic                      busy,
  output logic [CNT_W-1:0]          stall_cycles
);

  localparam int               c_NUM_REGS = 1 << REG_AW;
  localparam logic [LAT_W-1:0] c_LAT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0] c_LAT_ZERO = '0;
  localparam logic [CNT_W-1:0] c_SC_MAX   = {CNT_W{1'b1}};

  // Per-register cycles remaining until the pending write completes.
  logic [LAT_W-1:0]     r_cnt [c_NUM_REGS];
  logic [CNT_W-1:0]     r_stall_cycles;

  logic [NUM_SRC-1:0]   w_src_haz;
  logic [NUM_SRC-1:0]   w_fwd_hit;
  logic [LAT_W-1:0]     w_dest_cnt;
  logic                 w_waw_haz;
  logic                 w_stall;
  logic                 w_accept;
  logic                 w_load;
  logic [c_NUM_REGS-1:0] w_pending;

  // --------------------------------------------------------------------------
  // Source (RAW) checks. Every source looks at the registered counter only,
  // so a source naming the instruction's own destination sees the value
  // before this issue, and duplicated sources naturally agree.
  // --------------------------------------------------------------------------
  generate
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      logic [REG_AW-1:0] w_addr;
      logic [LAT_W-1:0]  w_cnt;

      assign w_addr = src_addr[s*REG_AW +: REG_AW];
      assign w_cnt  = r_cnt[w_addr];

      // With forwarding, a write finishing this cycle (count of one) can be
      // bypassed, so only counts above one block the read.
      assign w_src_haz[s] = src_used[s] &&
                            (fwd_en ? (w_cnt > c_LAT_ONE) : (w_cnt != c_LAT_ZERO));

      assign w_fwd_hit[s] = issue_valid && src_used[s] && fwd_en &&
                            (w_cnt == c_LAT_ONE);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Destination (WAW) check: a new write may not complete before an older
  // write to the same register, otherwise the older value would win.
  // --------------------------------------------------------------------------
  assign w_dest_cnt = r_cnt[issue_dest];
  assign w_waw_haz  = issue_wb_en && (w_dest_cnt > issue_lat);

  // Stall is purely combinational and still reported during a flush cycle.
  assign w_stall  = issue_valid && ((|w_src_haz) || w_waw_haz);

  // Flush suppresses acceptance; a zero-latency or non-writing instruction
  // is accepted but leaves no entry behind.
  assign w_accept = issue_valid && !w_stall && !flush;
  assign w_load   = w_accept && issue_wb_en && (issue_lat != c_LAT_ZERO);

  // --------------------------------------------------------------------------
  // Counter array. Priority per register: reset, flush, new load, decrement.
  // The load replaces the decrement so a freshly issued write starts at its
  // full latency.
  // --------------------------------------------------------------------------
  generate
    for (genvar r = 0; r < c_NUM_REGS; r++) begin : g_reg
      logic w_hit;
      assign w_hit = w_load && (issue_dest == REG_AW'(r));

      // Countdown for register r.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt[r] <= c_LAT_ZERO;
        end else if (flush) begin
          r_cnt[r] <= c_LAT_ZERO;
        end else if (w_hit) begin
          r_cnt[r] <= issue_lat;
        end else if (r_cnt[r] != c_LAT_ZERO) begin
          r_cnt[r] <= r_cnt[r] - c_LAT_ONE;
        end
      end

      assign w_pending[r] = (r_cnt[r] != c_LAT_ZERO);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stall performance counter, saturating at all-ones.
  // --------------------------------------------------------------------------
  // Count every edge on which the issue stage is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != c_SC_MAX)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall        = w_stall;
  assign fwd_hit      = w_fwd_hit;
  assign busy         = |w_pending;
  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard. The reference
//               keeps, per register, the absolute cycle at which its pending
//               write completes and derives remaining latency by subtraction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_dest = '0;
  logic        issue_wb_en = 1'b0;
  logic [2:0]  issue_lat = '0;
  logic [11:0] src_addr = '0;
  logic [2:0]  src_used = '0;
  logic        fwd_en = 1'b0;
  logic        flush = 1'b0;

  logic        stall, stall4;
  logic [2:0]  fwd_hit, fwd_hit4;
  logic        busy, busy4;
  logic [15:0] stall_cycles;
  logic [3:0]  stall_cycles4;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: completion cycle per register, plus stall counts.
  int ready [16];
  int cyc    = 0;
  int m_sc16 = 0;
  int m_sc4  = 0;
  bit m_st;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_wb_en(issue_wb_en), .issue_lat(issue_lat), .src_addr(src_addr),
    .src_used(src_used), .fwd_en(fwd_en), .flush(flush), .stall(stall),
    .fwd_hit(fwd_hit), .busy(busy), .stall_cycles(stall_cycles)
  );

  hazard_scoreboard #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_wb_en(issue_wb_en), .issue_lat(issue_lat), .src_addr(src_addr),
    .src_used(src_used), .fwd_en(fwd_en), .flush(flush), .stall(stall4),
    .fwd_hit(fwd_hit4), .busy(busy4), .stall_cycles(stall_cycles4)
  );

  // Cycles left before register r is written.
  function automatic int rem(input int r);
    return (ready[r] > cyc) ? ready[r] - cyc : 0;
  endfunction

  function automatic bit exp_stall();
    bit h = 1'b0;
    for (int s = 0; s < 3; s++)
      if (src_used[s] && rem(int'(src_addr[s*4 +: 4])) > (fwd_en ? 1 : 0)) h = 1'b1;
    if (issue_wb_en && rem(int'(issue_dest)) > int'(issue_lat)) h = 1'b1;
    return issue_valid && h;
  endfunction

  function automatic logic [2:0] exp_fwd();
    logic [2:0] f = '0;
    for (int s = 0; s < 3; s++)
      f[s] = issue_valid && src_used[s] && fwd_en && (rem(int'(src_addr[s*4 +: 4])) == 1);
    return f;
  endfunction

  function automatic bit exp_busy();
    bit b = 1'b0;
    for (int r = 0; r < 16; r++) if (rem(r) != 0) b = 1'b1;
    return b;
  endfunction

  // Reference update on each edge; reset clears everything immediately.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 16; r++) ready[r] = 0;
      m_sc16 = 0;
      m_sc4  = 0;
    end else begin
      m_st = exp_stall();
      if (m_st) begin
        if (m_sc16 < 65535) m_sc16 = m_sc16 + 1;
        if (m_sc4 < 15)     m_sc4  = m_sc4 + 1;
      end
      if (flush) begin
        for (int r = 0; r < 16; r++) ready[r] = 0;
      end else if (issue_valid && !m_st && issue_wb_en && issue_lat != 0) begin
        ready[issue_dest] = cyc + 1 + int'(issue_lat);
      end
      cyc = cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and compare all outputs.
  task automatic apply(input logic v, input logic [3:0] dest, input logic wb,
                       input logic [2:0] lat, input logic [11:0] sa,
                       input logic [2:0] su, input logic fe, input logic fl);
    @(negedge clk);
    issue_valid = v;  issue_dest = dest; issue_wb_en = wb; issue_lat = lat;
    src_addr    = sa; src_used   = su;   fwd_en      = fe; flush     = fl;
    #1;
    check("stall",         32'(stall),         32'(exp_stall()));
    check("fwd_hit",       32'(fwd_hit),       32'(exp_fwd()));
    check("busy",          32'(busy),          32'(exp_busy()));
    check("stall_cycles",  32'(stall_cycles),  32'(m_sc16));
    check("stall4",        32'(stall4),        32'(exp_stall()));
    check("fwd_hit4",      32'(fwd_hit4),      32'(exp_fwd()));
    check("busy4",         32'(busy4),         32'(exp_busy()));
    check("stall_cycles4", 32'(stall_cycles4), 32'(m_sc4));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 4'd0, 1'b0, 3'd0, 12'd0, 3'd0, 1'b0, 1'b0);
  endtask

  // Drop reset between edges while a write is pending; outputs clear at once.
  task automatic async_reset_pulse(input string tag);
    #1 rst_n = 1'b0;
    #1;
    check({tag, "_busy"}, 32'(busy),          32'd0);
    check({tag, "_sc"},   32'(stall_cycles),  32'd0);
    check({tag, "_sc4"},  32'(stall_cycles4), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] a;
    // Reset held: even a self-dependent request must not stall.
    apply(1'b1, 4'd2, 1'b1, 3'd1, {4'd2, 4'd2, 4'd2}, 3'b111, 1'b1, 1'b0);
    check("rst_stall", 32'(stall),   32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_fwd",   32'(fwd_hit), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // RAW without forwarding: r3 lat 3, one bubble, then read r3.
    apply(1'b1, 4'd3, 1'b1, 3'd3, 12'd0, 3'd0, 1'b0, 1'b0);
    idle(1);
    apply(1'b1, 4'd0, 1'b0, 3'd0, 12'd3, 3'b001, 1'b0, 1'b0);
    check("raw_s0", 32'(stall), 32'd1);
    apply(1'b1, 4'd0, 1'b0, 3'd0, 12'd3, 3'b001, 1'b0, 1'b0);
    check("raw_s1", 32'(stall), 32'd1);
    apply(1'b1, 4'd0, 1'b0, 3'd0, 12'd3, 3'b001, 1'b0, 1'b0);
    check("raw_s2", 32'(stall), 32'd0);
    check("raw_cnt", 32'(stall_cycles), 32'd2);
    idle(2);

    // RAW with forwarding: one stall, then the value comes from the bypass.
    apply(1'b1, 4'd3, 1'b1, 3'd3, 12'd0, 3'd0, 1'b1, 1'b0);
    idle(1);
    apply(1'b1, 4'd0, 1'b0, 3'd0, 12'd3, 3'b001, 1'b1, 1'b0);
    check("fwd_s0", 32'(stall), 32'd1);
    apply(1'b1, 4'd0, 1'b0, 3'd0, 12'd3, 3'b001, 1'b1, 1'b0);
    check("fwd_s1", 32'(stall), 32'd0);
    check("fwd_hit0", 32'(fwd_hit), 32'd1);
    idle(2);

    // WAW: r5 lat 6, bubble, then r5 lat 2 stalls 3 cycles and reloads to 2.
    apply(1'b1, 4'd5, 1'b1, 3'd6, 12'd0, 3'd0, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 4'd5, 1'b1, 3'd2, 12'd0, 3'd0, 1'b0, 1'b0);
      check("waw_stall", 32'(stall), 32'd1);
    end
    apply(1'b1, 4'd5, 1'b1, 3'd2, 12'd0, 3'd0, 1'b0, 1'b0);
    check("waw_accept", 32'(stall), 32'd0);
    apply(1'b1, 4'd0, 1'b0, 3'd0, 12'd5, 3'b001, 1'b0, 1'b0);
    check("waw_rl0", 32'(stall), 32'd1);
    apply(1'b1, 4'd0, 1'b0, 3'd0, 12'd5, 3'b001, 1'b0, 1'b0);
    check("waw_rl1", 32'(stall), 32'd1);
    apply(1'b1, 4'd0, 1'b0, 3'd0, 12'd5, 3'b001, 1'b0, 1'b0);
    check("waw_rl2", 32'(stall), 32'd0);
    idle(2);

    // Flush: r1 lat 4, then flush with a concurrent r7 issue that must vanish.
    apply(1'b1, 4'd1, 1'b1, 3'd4, 12'd0, 3'd0, 1'b0, 1'b0);
    apply(1'b1, 4'd7, 1'b1, 3'd5, 12'd0, 3'd0, 1'b0, 1'b1);
    apply(1'b1, 4'd0, 1'b0, 3'd0, {4'd0, 4'd7, 4'd1}, 3'b011, 1'b0, 1'b0);
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_busy",  32'(busy),  32'd0);
    idle(1);

    // Self-dependent re-issue keeps a hazard alive far past 15 stalled cycles.
    for (int i = 0; i < 40; i++)
      apply(1'b1, 4'd4, 1'b1, 3'd7, 12'd4, 3'b001, 1'b0, 1'b0);
    check("sat4", 32'(stall_cycles4), 32'd15);
    idle(8);

    // Asynchronous reset with r2 counting down from 5.
    apply(1'b1, 4'd2, 1'b1, 3'd5, 12'd0, 3'd0, 1'b0, 1'b0);
    idle(1);
    async_reset_pulse("arst");
    apply(1'b1, 4'd0, 1'b0, 3'd0, 12'd2, 3'b001, 1'b0, 1'b0);
    check("arst_src", 32'(stall), 32'd0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      logic [11:0] sa;
      a  = 4'($urandom_range(0, 5));
      sa = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      if ($urandom_range(0, 3) == 0) sa = {a, a, a};
      apply(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 5)),
            ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), sa,
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 24) == 0));
      if (i == 700) async_reset_pulse("rnd_arst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
